// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared constants and types for the fetch stage.
//   NOP_ENC       : bubble encoding (sll $0,$0,0)
//   RESET_PC_DFLT : default reset fetch address
//   npc_sel_e     : next-PC source select
package if_stage_pkg;

  localparam logic [31:0] NOP_ENC       = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEL_PC4,
    SEL_BPC,
    SEL_JPC,
    SEL_RA,
    SEL_HOLD
  } npc_sel_e;

  // Stall freezes everything, then redirects (jr > jump > branch), then remain_pc.
  function automatic npc_sel_e npc_select(input logic stall, input logic remain_pc,
                                          input logic branch, input logic jump,
                                          input logic jr);
    if (stall)          return SEL_HOLD;
    else if (jr)        return SEL_RA;
    else if (jump)      return SEL_JPC;
    else if (branch)    return SEL_BPC;
    else if (remain_pc) return SEL_HOLD;
    else                return SEL_PC4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: Control/imem <-> fetch-stage bundle.
//   Control side (master): stall, remain_pc, branch, jump, jr, bpc, jpc, ra, imem_inst
//   Fetch side   (slave) : pc, id_inst, id_pc4, id_valid
interface if_stage_if;
  logic        stall;
  logic        remain_pc;
  logic        branch;
  logic        jump;
  logic        jr;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic [31:0] ra;
  logic [31:0] imem_inst;
  logic [31:0] pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;

  modport master (
    output stall, remain_pc, branch, jump, jr, bpc, jpc, ra, imem_inst,
    input  pc, id_inst, id_pc4, id_valid
  );

  modport slave (
    input  stall, remain_pc, branch, jump, jr, bpc, jpc, ra, imem_inst,
    output pc, id_inst, id_pc4, id_valid
  );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst         : clock, synchronous active-high reset
//   hold_i           : keep current contents (highest after reset)
//   bubble_i         : load NOP, pc4=0, valid=0
//   inst_i, pc4_i    : fetched instruction and its PC+4 (loaded otherwise)
//   id_inst_o, id_pc4_o, id_valid_o : registered outputs
module if_id_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        bubble_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc4_o,
  output logic        id_valid_o
);

  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q,  pc4_d;
  logic        vld_q,  vld_d;

  always_comb begin
    inst_d = inst_q;
    pc4_d  = pc4_q;
    vld_d  = vld_q;
    if (!hold_i) begin
      if (bubble_i) begin
        inst_d = NOP_INST;
        pc4_d  = 32'h0;
        vld_d  = 1'b0;
      end else begin
        inst_d = inst_i;
        pc4_d  = pc4_i;
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q <= NOP_INST;
      pc4_q  <= 32'h0;
      vld_q  <= 1'b0;
    end else begin
      inst_q <= inst_d;
      pc4_q  <= pc4_d;
      vld_q  <= vld_d;
    end
  end

  assign id_inst_o  = inst_q;
  assign id_pc4_o   = pc4_q;
  assign id_valid_o = vld_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage. Owns the PC, the next-PC mux and the IF/ID register.
//   clk, rst : clock, synchronous active-high reset
//   bus      : if_stage_if.slave (Control hazard/redirect inputs, imem read data,
//              pc / id_inst / id_pc4 / id_valid outputs)
// Build option: IF_DELAY_SLOT_EN -- when defined, a redirect does not squash the
// instruction in IF (branch delay slot); otherwise it is replaced by a bubble.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
  parameter logic [31:0] NOP_INST = NOP_ENC
) (
  input  logic   clk,
  input  logic   rst,
  if_stage_if.slave bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4;
  logic        redir;
  logic        bubble;
  npc_sel_e    sel;

  assign pc4   = pc_q + 32'd4;  // wraps modulo 2^32
  assign redir = bus.jr | bus.jump | bus.branch;
  assign sel   = npc_select(bus.stall, bus.remain_pc, bus.branch, bus.jump, bus.jr);

  // Targets are word-aligned before they reach the PC.
  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      SEL_PC4:  pc_d = pc4;
      SEL_BPC:  pc_d = bus.bpc & ~32'h3;
      SEL_JPC:  pc_d = bus.jpc & ~32'h3;
      SEL_RA:   pc_d = bus.ra  & ~32'h3;
      SEL_HOLD: pc_d = pc_q;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

`ifdef IF_DELAY_SLOT_EN
  // Delay slot: the instruction behind a redirect still executes.
  assign bubble = bus.remain_pc & ~redir;
`else
  // Wrong-path instruction in IF is squashed on redirect.
  assign bubble = redir | bus.remain_pc;
`endif

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .hold_i    (bus.stall),
    .bubble_i  (bubble),
    .inst_i    (bus.imem_inst),
    .pc4_i     (pc4),
    .id_inst_o (bus.id_inst),
    .id_pc4_o  (bus.id_pc4),
    .id_valid_o(bus.id_valid)
  );

  assign bus.pc = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage; imem word = address ^ 32'hDEAD_0000.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

`ifdef IF_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0000;

  if_stage_if bus ();

  if_stage dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign bus.imem_inst = mem(bus.pc);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] pc4, input logic vld);
    chk({tag, ".pc"},    bus.pc,               pc);
    chk({tag, ".inst"},  bus.id_inst,          inst);
    chk({tag, ".pc4"},   bus.id_pc4,           pc4);
    chk({tag, ".valid"}, {31'h0, bus.id_valid}, {31'h0, vld});
  endtask

  task automatic clr();
    bus.stall = 0; bus.remain_pc = 0; bus.branch = 0; bus.jump = 0; bus.jr = 0;
  endtask

  initial begin
    clr();
    bus.bpc = 0; bus.jpc = 0; bus.ra = 0;
    rst = 1;
    tick();
    chk_all("reset", 32'h0, NOP, 32'h0, 1'b0);
    rst = 0;

    // free run 0,4,8,C,10
    tick(); chk_all("run1", 32'h4,  mem(32'h0), 32'h4,  1'b1);
    tick(); chk_all("run2", 32'h8,  mem(32'h4), 32'h8,  1'b1);
    tick(); chk_all("run3", 32'hC,  mem(32'h8), 32'hC,  1'b1);
    tick(); chk_all("run4", 32'h10, mem(32'hC), 32'h10, 1'b1);

    // stall with a concurrent branch: branch ignored
    bus.stall = 1; bus.branch = 1; bus.bpc = 32'h80;
    tick(); chk_all("stall1", 32'h10, mem(32'hC), 32'h10, 1'b1);
    tick(); chk_all("stall2", 32'h10, mem(32'hC), 32'h10, 1'b1);
    clr();
    tick(); chk_all("unstall", 32'h14, mem(32'h10), 32'h14, 1'b1);

    // jr beats jump and branch; low bits cleared
    bus.jr = 1; bus.jump = 1; bus.branch = 1;
    bus.ra = 32'h103; bus.jpc = 32'h200; bus.bpc = 32'h40;
    tick();
    chk_all("jr", 32'h100, DS ? mem(32'h14) : NOP, DS ? 32'h18 : 32'h0, DS);
    clr();

    // jump beats branch
    bus.jump = 1; bus.branch = 1; bus.jpc = 32'hC; bus.bpc = 32'h300;
    tick();
    chk("jump.pc", bus.pc, 32'hC);
    clr();

    // taken branch at 0x0C (target low bits cleared)
    bus.branch = 1; bus.bpc = 32'h43;
    tick();
    chk_all("br", 32'h40, DS ? mem(32'hC) : NOP, DS ? 32'h10 : 32'h0, DS);
    clr();
    tick(); chk_all("br_tgt", 32'h44, mem(32'h40), 32'h44, 1'b1);

    // remain_pc at 0x20
    bus.jump = 1; bus.jpc = 32'h20;
    tick(); chk("to20.pc", bus.pc, 32'h20);
    clr();
    bus.remain_pc = 1;
    tick(); chk_all("remain", 32'h20, NOP, 32'h0, 1'b0);
    clr();
    tick(); chk_all("after_rem", 32'h24, mem(32'h20), 32'h24, 1'b1);

    // pc wrap
    bus.jump = 1; bus.jpc = 32'hFFFF_FFFC;
    tick(); chk("top.pc", bus.pc, 32'hFFFF_FFFC);
    clr();
    tick(); chk_all("wrap", 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1'b1);
    tick(); chk_all("post_wrap", 32'h4, mem(32'h0), 32'h4, 1'b1);

    // reset wins over stall + redirect
    bus.stall = 1; bus.branch = 1; bus.bpc = 32'h40; rst = 1;
    tick(); chk_all("rst_stall", 32'h0, NOP, 32'h0, 1'b0);
    rst = 0; clr();
    tick(); chk_all("rst_run", 32'h4, mem(32'h0), 32'h4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
